// File: rtl/euryspace_uart_tx_if.sv
// euryspace_uart_tx_if: byte handshake between the bus-side register logic
// (master) and the UART transmitter FIFO (slave). A byte moves on a clock
// edge where valid_i and ready_o are both high.
`timescale 1ns/1ps

interface euryspace_uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o
  );
endinterface : euryspace_uart_tx_if

// File: rtl/euryspace_uart_tx.sv
// euryspace_uart_tx: byte FIFO feeding an 8N1 LSB-first UART serialiser with
// a fixed integer clock divisor. Back-to-back frames leave no idle gap.
// Optional even-parity bit between data and stop: define
// EURYSPACE_UART_TX_PARITY_EN (default build is plain 8N1).
`timescale 1ns/1ps

module euryspace_uart_tx #(
  parameter int unsigned DIVISOR = 434,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  euryspace_uart_tx_if.slave        bus,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic [FIFO_AW:0]          level_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef EURYSPACE_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;

  // Serialiser state
  logic [2:0]         state_q,  state_d;
  logic [CNT_W-1:0]   div_q,    div_d;
  logic [2:0]         bit_q,    bit_d;
  logic [7:0]         shift_q,  shift_d;
  logic               tx_q,     tx_d;
  logic               busy_q,   busy_d;
`ifdef EURYSPACE_UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               full_c;
  logic               nempty_c;
  logic               push_c;
  logic               pop_c;
  logic               bit_done_c;
  logic [7:0]         head_c;

  // Handshake and FIFO status decode
  assign full_c      = (level_q == LVL_W'(DEPTH));
  assign nempty_c    = (level_q != '0);
  assign bus.ready_o = ~full_c;
  assign push_c      = bus.valid_i & ~full_c;
  assign head_c      = mem_q[rd_ptr_q];
  assign bit_done_c  = (div_q == CNT_W'(DIVISOR - 1));

  // Next-state logic for the frame sequencer, shift register and bit timing
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop_c    = 1'b0;
`ifdef EURYSPACE_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (nempty_c) begin
          pop_c   = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_done_c) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done_c) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
`ifdef EURYSPACE_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

`ifdef EURYSPACE_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_c) begin
          div_d   = '0;
          state_d = ST_STOP;
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (bit_done_c) begin
          div_d = '0;
          bit_d = '0;
          // Chain straight into the next start bit when more data waits
          if (nempty_c) begin
            pop_c   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase

    // A pop loads the head byte; parity is captured before shifting destroys it
    if (pop_c) begin
      shift_d  = head_c;
`ifdef EURYSPACE_UART_TX_PARITY_EN
      parity_d = ^head_c;
`endif
    end
  end

  // Line level follows the state being entered, so tx_o is a clean flop output
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef EURYSPACE_UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy update; level counts separately from pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Busy reflects the cycle being entered: active frame or queued data
  always_comb begin
    busy_d = (state_d != ST_IDLE) || (level_d != '0);
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
`ifdef EURYSPACE_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef EURYSPACE_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care after reset so no reset here
  always_ff @(posedge wb_clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign level_o = level_q;

endmodule : euryspace_uart_tx

// File: doc/euryspace_uart_tx.md
Name: euryspace_uart_tx

Overview:
- Synthesizable UART transmitter with byte FIFO that drives the SoC `uart0_stx_pad_o` line.
- Sits directly upstream of the bench `uart_decoder`, which samples that line at 8680 ns per bit.
- Accepts bytes over a valid/ready handshake from the bus-side register logic.
- Serialises 8N1, LSB first, at a fixed integer clock divisor.

Parameters:
- DIVISOR, 434, `wb_clk_i` cycles per bit (50 MHz / 434 ≈ 115200 baud = 8680 ns); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 entries.

Ports:
- `wb_clk_i`  in  1  system clock; all logic on the rising edge.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept; combinational, equals (level != depth).
- `tx_o`  out  1  serial line, idle high, registered.
- `busy_o`  out  1  registered; high while the FSM is not IDLE or the FIFO is non-empty.
- `level_o`  out  FIFO_AW+1  current FIFO occupancy, registered.

Behaviour:
- Reset values (wb_rst_i=1 at an edge): tx_o=1, busy_o=0, level_o=0, ready_o=1, FSM=IDLE, bit counter=0, divisor counter=0. FIFO pointers cleared; stored data is don't-care.
- Push: on an edge with valid_i && ready_o, data_i is written; level_o increments at that edge.
- Pop: in IDLE with level_o != 0, the head byte is loaded into the shift register at the edge.
  - That edge decrements the level and moves the FSM to START.
- Simultaneous push and pop: level_o is unchanged and both operations take effect.
- Full: ready_o=0; data_i is ignored and never overwrites an entry.
- Pointers wrap modulo depth. Level is tracked separately, so full and empty are unambiguous.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: tx_o=1. Leaves only on a pop.
  - START: tx_o=0 for DIVISOR cycles, then DATA with bit index 0.
  - DATA: tx_o=shift[0] for DIVISOR cycles, then shift right and increment the bit index. After bit 7 go to STOP, or to PARITY if enabled.
  - STOP: tx_o=1 for DIVISOR cycles. Then go to START directly if the FIFO is non-empty (pop at that edge, no idle gap), else IDLE.
- Latency: byte accepted at edge N into an empty, idle block → pop at edge N+1 → tx_o falls after edge N+1.
- Frame length: exactly 10*DIVISOR cycles for 8N1.
- Divisor counter: counts 0..DIVISOR-1 and reloads to 0 on every state or bit advance. Width is $clog2(DIVISOR).
- tx_o is driven from a flop, so the line never glitches.
- Reset mid-frame: tx_o=1 at the next edge, the frame is aborted, and the FIFO is emptied.
- busy_o falls in the cycle after the final STOP bit completes with the FIFO empty.

Optional Feature:
- Macro: `EURYSPACE_UART_TX_PARITY_EN`.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_o = XOR of the 8 data bits (even parity) for DIVISOR cycles.
  - Frame is 11*DIVISOR cycles.
- When undefined:
  - No PARITY state and no parity logic; 8N1 only.
  - The bench `uart_decoder` requires this configuration.

Test Plan:
- Single byte, no parity, DIVISOR=434:
  - Push 0x55 at edge N.
  - tx_o=0 from N+1 for 434 cycles, then bits 1,0,1,0,1,0,1,0 of 434 cycles each, then stop=1.
  - busy_o=0 at N+1+4340+1; uart_decoder prints 'U'.
- Back-to-back fill, DIVISOR=434, valid_i held high for 18 cycles with bytes 0x00..0x11:
  - 17 bytes accepted; level_o=16 and ready_o=0 before the 18th edge.
  - Serial output shows 0x00..0x10 in order, with no idle gap between frames.
- Simultaneous push/pop:
  - At the STOP→START edge with level_o=3, push one byte; level_o stays 3.
- Reset mid-frame:
  - Assert wb_rst_i for 1 cycle during DATA bit 3 of 0xA5 with 5 bytes queued.
  - Next cycle: tx_o=1, level_o=0, busy_o=0, ready_o=1.
  - No further transitions on tx_o for 2000 cycles.
- Minimum divisor, DIVISOR=2:
  - Push 0xFF; tx_o is low for exactly 2 cycles, then high for 18 cycles; busy_o then falls.
- Parity (`EURYSPACE_UART_TX_PARITY_EN` defined, DIVISOR=434):
  - Push 0x07; bit 9 = 1, then stop.
  - Push 0x03; bit 9 = 0.
  - Each frame is 4774 cycles.
